// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two valid/ready requesters.
// Optional illegal-code check enabled by defining ALU_ARB_ILLEGAL_CHK_EN.
module alu_arbiter #(
  parameter int WIDTH = 64
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Req0Valid,
  output logic             Req0Ready,
  input  logic [3:0]       Req0Ctrl,
  input  logic [WIDTH-1:0] Req0A,
  input  logic [WIDTH-1:0] Req0B,
  input  logic             Req1Valid,
  output logic             Req1Ready,
  input  logic [3:0]       Req1Ctrl,
  input  logic [WIDTH-1:0] Req1A,
  input  logic [WIDTH-1:0] Req1B,
  output logic             Resp0Valid,
  input  logic             Resp0Ready,
  output logic [WIDTH-1:0] Resp0Data,
  output logic             Resp0Zero,
  output logic             Resp1Valid,
  input  logic             Resp1Ready,
  output logic [WIDTH-1:0] Resp1Data,
  output logic             Resp1Zero,
  output logic [3:0]       AluCtrl,
  output logic [WIDTH-1:0] AluA,
  output logic [WIDTH-1:0] AluB,
  input  logic [WIDTH-1:0] AluW,
  input  logic             AluZero,
  output logic             IllegalOp
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  logic [1:0]       state;
  logic             last_grant;
  logic             grant;
  logic             sel;
  logic             accept;
  logic             resp_hs;
  logic             illegal_req;
  logic [3:0]       req_ctrl;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [WIDTH-1:0] resp_data;
  logic             resp_zero;

  always_comb begin
    // On a tie the requester that was not served last wins.
    sel         = (Req0Valid && Req1Valid) ? ~last_grant : Req1Valid;
    Req0Ready   = (state == IDLE) && !Reset && Req0Valid && !sel;
    Req1Ready   = (state == IDLE) && !Reset && Req1Valid && sel;
    accept      = Req0Ready || Req1Ready;
    req_ctrl    = sel ? Req1Ctrl : Req0Ctrl;
    req_a       = sel ? Req1A : Req0A;
    req_b       = sel ? Req1B : Req0B;
    Resp0Valid  = (state == RESP) && !grant;
    Resp1Valid  = (state == RESP) && grant;
    resp_hs     = (Resp0Valid && Resp0Ready) || (Resp1Valid && Resp1Ready);
`ifdef ALU_ARB_ILLEGAL_CHK_EN
    illegal_req = !(req_ctrl inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111});
`else
    illegal_req = 1'b0;
`endif
  end

  // One result register feeds both response ports; only Valid is steered.
  assign Resp0Data = resp_data;
  assign Resp1Data = resp_data;
  assign Resp0Zero = resp_zero;
  assign Resp1Zero = resp_zero;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant      <= 1'b0;
      AluCtrl    <= '0;
      AluA       <= '0;
      AluB       <= '0;
      resp_data  <= '0;
      resp_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            grant <= sel;
            if (illegal_req) begin
              resp_data <= '0;
              resp_zero <= 1'b1;
              state     <= RESP;
            end else begin
              AluCtrl <= req_ctrl;
              AluA    <= req_a;
              AluB    <= req_b;
              state   <= ISSUE;
            end
          end
        end
        ISSUE: begin
          resp_data <= AluW;
          resp_zero <= AluZero;
          state     <= RESP;
        end
        RESP: begin
          if (resp_hs) begin
            last_grant <= grant;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_ARB_ILLEGAL_CHK_EN
  logic illegal_seen;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      illegal_seen <= 1'b0;
    end else if (accept && illegal_req) begin
      illegal_seen <= 1'b1;
    end
  end

  assign IllegalOp = illegal_seen;
`else
  assign IllegalOp = 1'b0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a transaction-level model checked every cycle
// plus hand-computed literal expectations for each scenario.
module tb_alu_arbiter;

  localparam int W = 64;
  localparam logic [3:0] C_AND = 4'b0000, C_OR = 4'b0001, C_ADD = 4'b0010,
                         C_SUB = 4'b0110, C_PASSB = 4'b0111;

  logic         CLK = 1'b0;
  logic         Reset = 1'b1;
  logic         Req0Valid = 1'b0, Req1Valid = 1'b0;
  logic         Req0Ready, Req1Ready;
  logic [3:0]   Req0Ctrl = '0, Req1Ctrl = '0;
  logic [W-1:0] Req0A = '0, Req0B = '0, Req1A = '0, Req1B = '0;
  logic         Resp0Valid, Resp1Valid;
  logic         Resp0Ready = 1'b1, Resp1Ready = 1'b1;
  logic [W-1:0] Resp0Data, Resp1Data;
  logic         Resp0Zero, Resp1Zero;
  logic [3:0]   AluCtrl;
  logic [W-1:0] AluA, AluB, AluW;
  logic         AluZero;
  logic         IllegalOp;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  alu_arbiter #(.WIDTH(W)) dut (
    .CLK(CLK), .Reset(Reset),
    .Req0Valid(Req0Valid), .Req0Ready(Req0Ready), .Req0Ctrl(Req0Ctrl), .Req0A(Req0A), .Req0B(Req0B),
    .Req1Valid(Req1Valid), .Req1Ready(Req1Ready), .Req1Ctrl(Req1Ctrl), .Req1A(Req1A), .Req1B(Req1B),
    .Resp0Valid(Resp0Valid), .Resp0Ready(Resp0Ready), .Resp0Data(Resp0Data), .Resp0Zero(Resp0Zero),
    .Resp1Valid(Resp1Valid), .Resp1Ready(Resp1Ready), .Resp1Data(Resp1Data), .Resp1Zero(Resp1Zero),
    .AluCtrl(AluCtrl), .AluA(AluA), .AluB(AluB), .AluW(AluW), .AluZero(AluZero),
    .IllegalOp(IllegalOp)
  );

  function automatic logic [W-1:0] alu_fn(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    case (c)
      C_AND:   return a & b;
      C_OR:    return a | b;
      C_ADD:   return a + b;
      C_SUB:   return a - b;
      C_PASSB: return b;
      default: return '0;
    endcase
  endfunction

  function automatic bit is_legal(input logic [3:0] c);
    return c == C_AND || c == C_OR || c == C_ADD || c == C_SUB || c == C_PASSB;
  endfunction

  // Behavioural ALU that the arbiter drives.
  assign AluW    = alu_fn(AluCtrl, AluA, AluB);
  assign AluZero = (AluW == '0);

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: one outstanding operation, response visible m_lat cycles after accept.
  bit           m_init = 0;
  bit           m_busy;
  int           m_who, m_age, m_lat;
  bit           m_last;
  logic [3:0]   m_ctrl;
  logic [W-1:0] m_a, m_b, m_data, m_pend;
  logic         m_zero, m_pzero, m_ill;

  always @(negedge CLK) begin
    bit both, gsel, er0, er1, ev0, ev1;
    logic [3:0]   c;
    logic [W-1:0] a, b;
    both = Req0Valid && Req1Valid;
    gsel = both ? !m_last : Req1Valid;
    er0  = m_init && !Reset && !m_busy && Req0Valid && !gsel;
    er1  = m_init && !Reset && !m_busy && Req1Valid && gsel;
    ev0  = m_busy && m_age >= m_lat && m_who == 0;
    ev1  = m_busy && m_age >= m_lat && m_who == 1;
    if (m_init) begin
      chk("req0_ready", {63'd0, Req0Ready}, {63'd0, er0});
      chk("req1_ready", {63'd0, Req1Ready}, {63'd0, er1});
      chk("resp0_valid", {63'd0, Resp0Valid}, {63'd0, ev0});
      chk("resp1_valid", {63'd0, Resp1Valid}, {63'd0, ev1});
      chk("resp0_data", Resp0Data, m_data);
      chk("resp1_data", Resp1Data, m_data);
      chk("resp0_zero", {63'd0, Resp0Zero}, {63'd0, m_zero});
      chk("resp1_zero", {63'd0, Resp1Zero}, {63'd0, m_zero});
      chk("alu_ctrl", {60'd0, AluCtrl}, {60'd0, m_ctrl});
      chk("alu_a", AluA, m_a);
      chk("alu_b", AluB, m_b);
      chk("illegal_op", {63'd0, IllegalOp}, {63'd0, m_ill});
    end
    // Advance the model to the state after the coming rising edge.
    if (Reset) begin
      m_init = 1; m_busy = 0; m_last = 1; m_age = 0; m_lat = 2; m_who = 0;
      m_ctrl = '0; m_a = '0; m_b = '0; m_data = '0; m_zero = 0; m_ill = 0;
      m_pend = '0; m_pzero = 0;
    end else if (m_busy) begin
      if (m_age >= m_lat && ((m_who == 0 && Resp0Ready) || (m_who == 1 && Resp1Ready))) begin
        m_busy = 0;
        m_last = m_who[0];
      end else begin
        if (m_age == 1 && m_lat == 2) begin
          m_data = m_pend;
          m_zero = m_pzero;
        end
        m_age++;
      end
    end else if (er0 || er1) begin
      c = er1 ? Req1Ctrl : Req0Ctrl;
      a = er1 ? Req1A : Req0A;
      b = er1 ? Req1B : Req0B;
      m_busy = 1; m_who = er1 ? 1 : 0; m_age = 1;
`ifdef ALU_ARB_ILLEGAL_CHK_EN
      if (!is_legal(c)) begin
        m_lat = 1; m_data = '0; m_zero = 1; m_ill = 1;
      end else
`endif
      begin
        m_lat = 2; m_ctrl = c; m_a = a; m_b = b;
        m_pend = alu_fn(c, a, b);
        m_pzero = (m_pend == '0);
      end
    end
  end

  task automatic wait_ready(input int r);
    int n;
    n = 0;
    @(negedge CLK);
    while (!(r == 0 ? Req0Ready : Req1Ready) && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk("ready_wait", {63'd0, (r == 0 ? Req0Ready : Req1Ready)}, 64'd1);
  endtask

  task automatic op(input int r, input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                    input logic [W-1:0] ed, input logic ez, input int elat, output logic [3:0] issue_ctrl);
    int lat;
    bit v;
    @(posedge CLK); #1;
    if (r == 0) begin Req0Valid = 1; Req0Ctrl = c; Req0A = a; Req0B = b; end
    else        begin Req1Valid = 1; Req1Ctrl = c; Req1A = a; Req1B = b; end
    wait_ready(r);
    @(posedge CLK); #1;
    if (r == 0) Req0Valid = 0; else Req1Valid = 0;
    lat = 0;
    issue_ctrl = 'x;
    do begin
      lat++;
      @(negedge CLK);
      if (lat == 1) issue_ctrl = AluCtrl;
      v = (r == 0) ? Resp0Valid : Resp1Valid;
    end while (!v && lat < 20);
    chk("op_latency", lat, elat);
    chk("op_data", (r == 0) ? Resp0Data : Resp1Data, ed);
    chk("op_zero", {63'd0, (r == 0) ? Resp0Zero : Resp1Zero}, {63'd0, ez});
  endtask

  initial begin
    logic [3:0] ic;
    int order[$];
    int c0, c1, n;
    int exp_order[8];
    exp_order = '{0, 1, 0, 1, 0, 1, 0, 1};

    repeat (2) @(posedge CLK);
    #1 Reset = 0;
    @(negedge CLK);
    chk("rst_resp0_valid", {63'd0, Resp0Valid}, 64'd0);
    chk("rst_alu_ctrl", {60'd0, AluCtrl}, 64'd0);
    chk("rst_data", Resp0Data, 64'd0);
    chk("rst_illegal", {63'd0, IllegalOp}, 64'd0);

    op(0, C_ADD, 64'd5, 64'd7, 64'd12, 1'b0, 2, ic);
    chk("add_issue_ctrl", {60'd0, ic}, 64'd2);
    op(1, C_SUB, 64'd9, 64'd9, 64'd0, 1'b1, 2, ic);
    op(1, C_SUB, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 2, ic);

    // Fairness: both requesters continuously valid for four operations each.
    @(posedge CLK); #1;
    Req0Valid = 1; Req0Ctrl = C_OR;    Req0A = 64'h10; Req0B = 64'h01;
    Req1Valid = 1; Req1Ctrl = C_PASSB; Req1A = 64'h0;  Req1B = 64'hAB;
    c0 = 0; c1 = 0; n = 0;
    while ((c0 < 4 || c1 < 4) && n < 100) begin
      @(negedge CLK);
      if (Req0Valid && Req0Ready) begin order.push_back(0); c0++; end
      if (Req1Valid && Req1Ready) begin order.push_back(1); c1++; end
      @(posedge CLK); #1;
      if (c0 >= 4) Req0Valid = 0;
      if (c1 >= 4) Req1Valid = 0;
      n++;
    end
    chk("fair_count", order.size(), 8);
    for (int i = 0; i < 8; i++)
      chk("fair_order", (i < order.size()) ? order[i] : -1, exp_order[i]);
    repeat (4) @(posedge CLK);

    // Held response with a competing requester waiting.
    #1 Resp0Ready = 0;
    Req0Valid = 1; Req0Ctrl = C_ADD; Req0A = 64'd100; Req0B = 64'd23;
    wait_ready(0);
    @(posedge CLK); #1;
    Req0Valid = 0;
    Req1Valid = 1; Req1Ctrl = C_OR; Req1A = 64'd1; Req1B = 64'd2;
    n = 0;
    do begin @(negedge CLK); n++; end while (!Resp0Valid && n < 20);
    chk("hold_first", Resp0Data, 64'd123);
    repeat (5) begin
      @(negedge CLK);
      chk("hold_valid", {63'd0, Resp0Valid}, 64'd1);
      chk("hold_data", Resp0Data, 64'd123);
      chk("hold_req1_ready", {63'd0, Req1Ready}, 64'd0);
    end
    @(posedge CLK); #1 Resp0Ready = 1;
    @(negedge CLK);
    chk("hs_cycle_req1_ready", {63'd0, Req1Ready}, 64'd0);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("after_hs_req1_ready", {63'd0, Req1Ready}, 64'd1);
    @(posedge CLK); #1 Req1Valid = 0;
    n = 0;
    do begin @(negedge CLK); n++; end while (!Resp1Valid && n < 20);
    chk("req1_or_data", Resp1Data, 64'd3);
    repeat (2) @(posedge CLK);

    // Reset during ISSUE drops the operation.
    #1 Req0Valid = 1; Req0Ctrl = C_ADD; Req0A = 64'd1; Req0B = 64'd1;
    wait_ready(0);
    @(posedge CLK); #1;
    Req0Valid = 0; Reset = 1;
    @(posedge CLK); #1 Reset = 0;
    @(negedge CLK);
    chk("midrst_valid", {63'd0, Resp0Valid}, 64'd0);
    chk("midrst_alu_ctrl", {60'd0, AluCtrl}, 64'd0);
    chk("midrst_alu_a", AluA, 64'd0);
    chk("midrst_data", Resp0Data, 64'd0);
    repeat (4) begin
      @(negedge CLK);
      chk("midrst_no_resp", {63'd0, Resp0Valid}, 64'd0);
    end
    op(0, C_AND, 64'hF0, 64'h3C, 64'h30, 1'b0, 2, ic);

    // Undefined control code.
`ifdef ALU_ARB_ILLEGAL_CHK_EN
    op(1, 4'b0011, 64'd5, 64'd7, 64'd0, 1'b1, 1, ic);
    chk("illegal_set", {63'd0, IllegalOp}, 64'd1);
    op(0, C_ADD, 64'd2, 64'd3, 64'd5, 1'b0, 2, ic);
    chk("illegal_sticky", {63'd0, IllegalOp}, 64'd1);
`else
    op(1, 4'b0011, 64'd5, 64'd7, 64'd0, 1'b1, 2, ic);
    chk("illegal_tied", {63'd0, IllegalOp}, 64'd0);
    op(0, C_ADD, 64'd2, 64'd3, 64'd5, 1'b0, 2, ic);
    chk("illegal_still_tied", {63'd0, IllegalOp}, 64'd0);
`endif
    repeat (3) @(posedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one 64-bit ALU between two requesters, e.g. the execute stage and a background address/compare unit. Each requester presents an ALU control code and two operands on a valid/ready request channel. The block arbitrates round-robin, drives the ALU from registered operands, captures the ALU result and Zero flag, and returns them on a valid/ready response channel. It sits between the requesters and the ALU instance and is the only driver of the ALU's control and operand inputs.

## Interface
- WIDTH, 64, operand/result width
- CLK  in  1  clock; all state changes on rising edge
- Reset  in  1  synchronous, active-high
- Req0Valid / Req1Valid  in  1  request present
- Req0Ready / Req1Ready  out  1  request accepted this cycle when high with Valid
- Req0Ctrl / Req1Ctrl  in  4  ALU control code (AND=0000, OR=0001, ADD=0010, SUB=0110, PassB=0111)
- Req0A / Req1A, Req0B / Req1B  in  WIDTH  operands A, B
- Resp0Valid / Resp1Valid  out  1  result available
- Resp0Ready / Resp1Ready  in  1  requester takes result
- Resp0Data / Resp1Data  out  WIDTH  captured ALU result
- Resp0Zero / Resp1Zero  out  1  captured ALU Zero flag
- AluCtrl  out  4  to ALU control input (registered)
- AluA / AluB  out  WIDTH  to ALU operand buses (registered)
- AluW  in  WIDTH  ALU result bus
- AluZero  in  1  ALU Zero flag
- IllegalOp  out  1  sticky illegal-code flag (see Configuration)

## Operation
- States: IDLE, ISSUE, RESP.
- IDLE:
  - If exactly one ReqNValid is high, grant it.
  - If both are high, grant the requester not equal to LastGrant.
  - ReqNReady is combinational, high only in IDLE and only for the granted requester; the other Ready is 0.
  - On Valid&Ready: latch Ctrl/A/B into AluCtrl/AluA/AluB, record Grant, go to ISSUE.
- ISSUE (one cycle): the ALU sees the registered operands. Capture AluW into RespData and AluZero into RespZero at the clock edge, then go to RESP.
- RESP:
  - RespNValid is high for the granted requester only.
  - Data/Zero are held stable until RespNReady.
  - On RespNValid&RespNReady: set LastGrant←Grant and go to IDLE.
  - No new request is accepted in RESP or ISSUE.
- Both RespData ports are driven from one result register; only the Valid bit is steered.
- AluCtrl/AluA/AluB hold their last issued value outside ISSUE.
- Requesters must keep Ctrl/A/B stable while Valid is high without Ready. Arbitration may re-evaluate each IDLE cycle.
- Width rule: results are WIDTH bits, with no carry/overflow output. SUB wraps modulo 2^WIDTH.

## Timing
- Reset (synchronous) sets:
  - state=IDLE, LastGrant=1 (requester 0 wins the first tie)
  - all Ready/Valid=0, AluCtrl=0, AluA=AluB=0, RespData=0, RespZero=0, IllegalOp=0
- Reset mid-transaction drops the transaction with no response. Reset has priority over every other event.
- Latency:
  - Accept at edge T; ISSUE during cycle T+1; RespValid is high from cycle T+2.
  - Minimum of 3 cycles per operation when RespReady is held high.
- Back-to-back: the response handshake at edge R returns to IDLE, and the next request can be accepted in cycle R+1.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1.
- A requester deasserting Valid in IDLE before Ready has no effect; there is no latching without a handshake.

## Configuration
- ALU_ARB_ILLEGAL_CHK_EN defined:
  - A request whose Ctrl is not in {0000,0001,0010,0110,0111} is accepted normally, but ISSUE is skipped.
  - Next cycle, go directly to RESP with RespData=0 and RespZero=1.
  - AluCtrl/AluA/AluB are not updated for an illegal request.
  - IllegalOp is set and stays high until Reset.
- Undefined:
  - All codes are issued to the ALU unchanged; the ALU returns 0 for undefined codes.
  - IllegalOp is tied 0.

## Test plan
- Reset, then Req0 ADD A=5 B=7 with Resp0Ready=1 -> Req0Ready in accept cycle; Resp0Valid exactly 2 cycles later with Data=12, Zero=0; AluCtrl=0010 during ISSUE.
- Req1 SUB A=9 B=9 -> Resp1Data=0, Resp1Zero=1; SUB A=0 B=1 -> Data=0xFFFF_FFFF_FFFF_FFFF, Zero=0.
- Both requesters valid continuously, 4 operations each -> grant order 0,1,0,1,…; Resp0Valid and Resp1Valid never high together.
- Resp0Ready held low 5 cycles -> Resp0Valid and Data stable; Req1Valid high the whole time gets no Ready until the cycle after the Resp0 handshake.
- Reset asserted during ISSUE -> next cycle all outputs at reset values, no response for the dropped request; Req0 AND A=0xF0 B=0x3C afterwards -> Data=0x30.
- With ALU_ARB_ILLEGAL_CHK_EN: Ctrl=0011 -> response 1 cycle after accept, Data=0, Zero=1, IllegalOp=1 and sticky. Without the macro: response at 2 cycles with the ALU's output (0), IllegalOp=0.
